// File: rtl/display_pkg.sv
// Shared types, segment codes and the BCD-to-7-segment helper for the display controller.
package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    EXIBE    = 2'd2
  } estado_t;

  // Active-low segments, ordered abcdefg
  localparam logic [6:0] SEG_ZERO    = 7'b0000001;
  localparam logic [6:0] SEG_UM      = 7'b1001111;
  localparam logic [6:0] SEG_DOIS    = 7'b0010010;
  localparam logic [6:0] SEG_TRES    = 7'b0000110;
  localparam logic [6:0] SEG_QUATRO  = 7'b1001100;
  localparam logic [6:0] SEG_CINCO   = 7'b0100100;
  localparam logic [6:0] SEG_SEIS    = 7'b0100000;
  localparam logic [6:0] SEG_SETE    = 7'b0001111;
  localparam logic [6:0] SEG_OITO    = 7'b0000000;
  localparam logic [6:0] SEG_NOVE    = 7'b0000100;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO   = 7'b1111110;

  localparam logic [31:0] LIMITE_DISPLAY = 32'd9999;

  function automatic logic [6:0] bcd_para_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = SEG_UM;
      4'd2:    seg = SEG_DOIS;
      4'd3:    seg = SEG_TRES;
      4'd4:    seg = SEG_QUATRO;
      4'd5:    seg = SEG_CINCO;
      4'd6:    seg = SEG_SEIS;
      4'd7:    seg = SEG_SETE;
      4'd8:    seg = SEG_OITO;
      4'd9:    seg = SEG_NOVE;
      default: seg = SEG_APAGADO;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/conversor_bcd_serial.sv
// Serial 14-bit binary to 4-digit BCD converter (shift-add-3), one bit per clock.
module conversor_bcd_serial
  import display_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inicia,
  input  logic [13:0] valor,
  output logic        pronto,
  output logic [15:0] bcd
);

  // [29:14] BCD accumulator, [13:0] binary bits still to be shifted in
  logic [29:0] desl_q;
  logic [29:0] ajustado;
  logic [3:0]  cont_q;
  logic        ativo_q;
  logic        pronto_q;

  always_comb begin
    ajustado = desl_q;
    for (int i = 0; i < 4; i++) begin
      if (desl_q[14+4*i +: 4] >= 4'd5) begin
        ajustado[14+4*i +: 4] = desl_q[14+4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      desl_q   <= '0;
      cont_q   <= '0;
      ativo_q  <= 1'b0;
      pronto_q <= 1'b0;
    end else if (inicia) begin
      desl_q   <= {16'd0, valor};
      cont_q   <= '0;
      ativo_q  <= 1'b1;
      pronto_q <= 1'b0;
    end else if (ativo_q) begin
      desl_q <= {ajustado[28:0], 1'b0};
      cont_q <= cont_q + 4'd1;
      if (cont_q == 4'd13) begin
        ativo_q  <= 1'b0;
        pronto_q <= 1'b1;
      end
    end
  end

  assign pronto = pronto_q;
  assign bcd    = desl_q[29:14];

endmodule

// File: rtl/display_controlador.sv
// Round-robin scheduler sharing a 4-digit 7-segment display among N_FONTES requesters.
// Define DISPLAY_ZEROS_ESQUERDA_EN to blank leading zero digits.
module display_controlador
  import display_pkg::*;
#(
  parameter int N_FONTES    = 4,
  parameter int TEMPO_EXIBE = 1000,
  parameter int LARG_PONT   = $clog2(N_FONTES)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_FONTES-1:0]   req,
  input  logic [32*N_FONTES-1:0] dado,
  output logic [N_FONTES-1:0]   ack,
  output logic [6:0]            saida1,
  output logic [6:0]            saida2,
  output logic [6:0]            saida3,
  output logic [6:0]            saida4,
  output logic [LARG_PONT-1:0]  fonte_ativa,
  output logic                  estouro,
  output logic                  ocupado
);

  estado_t              estado_q;
  logic [31:0]          valor_q;
  logic [LARG_PONT-1:0] fonte_q;
  logic [LARG_PONT-1:0] ult_q;
  logic [N_FONTES-1:0]  ack_q;
  logic [6:0]           seg1_q, seg2_q, seg3_q, seg4_q;
  logic [LARG_PONT-1:0] fonte_ativa_q;
  logic                 estouro_q;
  logic                 ocupado_q;
  logic                 ov_q;
  logic [31:0]          cont_q;

  logic                 achou;
  logic [LARG_PONT-1:0] conc;
  logic [31:0]          dado_sel;
  logic                 inicia;
  logic                 pronto;
  logic [15:0]          bcd;
  logic [6:0]           seg1_c, seg2_c, seg3_c, seg4_c;

  // Search upward from the source after the last one served, wrapping around
  always_comb begin
    achou = 1'b0;
    conc  = '0;
    for (int i = 1; i <= N_FONTES; i++) begin
      if (!achou && req[(int'(ult_q) + i) % N_FONTES]) begin
        achou = 1'b1;
        conc  = LARG_PONT'((int'(ult_q) + i) % N_FONTES);
      end
    end
  end

  assign dado_sel = dado[32*conc +: 32];
  // The converter starts on the grant edge so its 14 steps overlap the CONVERTE wait
  assign inicia   = (estado_q == OCIOSO) && achou;

  conversor_bcd_serial u_conversor (
    .clock   (clock),
    .reset_n (reset_n),
    .inicia  (inicia),
    .valor   (dado_sel[13:0]),
    .pronto  (pronto),
    .bcd     (bcd)
  );

  always_comb begin
    seg1_c = bcd_para_seg(bcd[3:0]);
    seg2_c = bcd_para_seg(bcd[7:4]);
    seg3_c = bcd_para_seg(bcd[11:8]);
    seg4_c = bcd_para_seg(bcd[15:12]);
`ifdef DISPLAY_ZEROS_ESQUERDA_EN
    if (bcd[15:12] == 4'd0) begin
      seg4_c = SEG_APAGADO;
      if (bcd[11:8] == 4'd0) begin
        seg3_c = SEG_APAGADO;
        if (bcd[7:4] == 4'd0) begin
          seg2_c = SEG_APAGADO;
        end
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= OCIOSO;
      valor_q       <= '0;
      fonte_q       <= '0;
      ult_q         <= LARG_PONT'(N_FONTES - 1);
      ack_q         <= '0;
      seg1_q        <= SEG_ZERO;
      seg2_q        <= SEG_ZERO;
      seg3_q        <= SEG_ZERO;
      seg4_q        <= SEG_ZERO;
      fonte_ativa_q <= '0;
      estouro_q     <= 1'b0;
      ocupado_q     <= 1'b0;
      ov_q          <= 1'b0;
      cont_q        <= '0;
    end else begin
      ack_q <= '0;
      unique case (estado_q)
        OCIOSO: begin
          if (achou) begin
            valor_q   <= dado_sel;
            fonte_q   <= conc;
            ack_q     <= N_FONTES'(1) << conc;
            ov_q      <= 1'b0;
            ocupado_q <= 1'b1;
            estado_q  <= CONVERTE;
          end
        end
        CONVERTE: begin
          if (ov_q) begin
            seg1_q        <= SEG_TRACO;
            seg2_q        <= SEG_TRACO;
            seg3_q        <= SEG_TRACO;
            seg4_q        <= SEG_TRACO;
            estouro_q     <= 1'b1;
            fonte_ativa_q <= fonte_q;
            cont_q        <= '0;
            estado_q      <= EXIBE;
          end else if (valor_q > LIMITE_DISPLAY) begin
            ov_q <= 1'b1;
          end else if (pronto) begin
            seg1_q        <= seg1_c;
            seg2_q        <= seg2_c;
            seg3_q        <= seg3_c;
            seg4_q        <= seg4_c;
            estouro_q     <= 1'b0;
            fonte_ativa_q <= fonte_q;
            cont_q        <= '0;
            estado_q      <= EXIBE;
          end
        end
        EXIBE: begin
          if (cont_q == 32'(TEMPO_EXIBE - 1)) begin
            ult_q     <= fonte_q;
            ocupado_q <= 1'b0;
            estado_q  <= OCIOSO;
          end else begin
            cont_q <= cont_q + 32'd1;
          end
        end
        default: begin
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign saida1      = seg1_q;
  assign saida2      = seg2_q;
  assign saida3      = seg3_q;
  assign saida4      = seg4_q;
  assign fonte_ativa = fonte_ativa_q;
  assign estouro     = estouro_q;
  assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_display_controlador.sv
// Scoreboard bench for display_controlador: random request batches against a round-robin/decimal model.
module tb_display_controlador;

  localparam int N = 4;
  localparam int T = 4;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [32*N-1:0] dado;
  logic [N-1:0]  ack;
  logic [6:0]    saida1, saida2, saida3, saida4;
  logic [1:0]    fonte_ativa;
  logic          estouro, ocupado;

  display_controlador #(.N_FONTES(N), .TEMPO_EXIBE(T)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .dado        (dado),
    .ack         (ack),
    .saida1      (saida1),
    .saida2      (saida2),
    .saida3      (saida3),
    .saida4      (saida4),
    .fonte_ativa (fonte_ativa),
    .estouro     (estouro),
    .ocupado     (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned src;
    logic [31:0] valor;
  } item_t;

  item_t exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ult;

  logic [6:0] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  localparam logic [27:0] DISP_RESET = {4{7'b0000001}};

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nome, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] esperado(input logic [31:0] v);
    int d0, d1, d2, d3;
    logic [27:0] r;
    if (v > 32'd9999) return {4{7'b1111110}};
    d0 = int'(v % 10);
    d1 = int'((v / 10) % 10);
    d2 = int'((v / 100) % 10);
    d3 = int'(v / 1000);
    r = {tab[d3], tab[d2], tab[d1], tab[d0]};
`ifdef DISPLAY_ZEROS_ESQUERDA_EN
    if (d3 == 0) begin
      r[27:21] = 7'b1111111;
      if (d2 == 0) begin
        r[20:14] = 7'b1111111;
        if (d1 == 0) r[13:7] = 7'b1111111;
      end
    end
`endif
    return r;
  endfunction

  // Monitor: every ack pops one expectation and follows that display period
  initial begin
    item_t it;
    int lat;
    bit aborted;
    logic [27:0] e;
    logic [27:0] prev;
    prev = DISP_RESET;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = DISP_RESET;
      end else if (ack != '0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack got=%b expected=none", ack);
        end else begin
          it = exp_q.pop_front();
          chk("ack_onehot", 64'(ack), 64'(4'b1 << it.src));
          lat = (it.valor > 32'd9999) ? 2 : 15;
          e = esperado(it.valor);
          aborted = 1'b0;
          for (int c = 1; c < lat + T && !aborted; c++) begin
            @(negedge clock);
            if (!reset_n) begin
              aborted = 1'b1;
              prev = DISP_RESET;
            end else begin
              chk("ack_quiet", 64'(ack), 64'd0);
              chk("ocupado_busy", 64'(ocupado), 64'd1);
              if (c == lat - 1)
                chk("display_not_early", 64'({saida4, saida3, saida2, saida1}), 64'(prev));
              if (c >= lat) begin
                chk("digits", 64'({saida4, saida3, saida2, saida1}), 64'(e));
                chk("fonte_ativa", 64'(fonte_ativa), 64'(it.src));
                chk("estouro", 64'(estouro), 64'(it.valor > 32'd9999));
              end
            end
          end
          if (!aborted) begin
            prev = e;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic set_dado(input int s, input logic [31:0] v);
    dado[32*s +: 32] = v;
  endtask

  task automatic predict(input logic [N-1:0] r, input int n);
    item_t it;
    int g;
    for (int k = 0; k < n; k++) begin
      g = -1;
      for (int i = 1; i <= N && g < 0; i++)
        if (r[(ult + i) % N]) g = (ult + i) % N;
      it.src = g;
      it.valor = dado[32*g +: 32];
      exp_q.push_back(it);
      ult = g;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int c = 0; c < budget && done_cnt < target; c++) begin
      @(negedge clock);
      #1;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL batch_timeout done=%0d expected=%0d", done_cnt, target);
      exp_q.delete();
    end
  endtask

  task automatic run_batch(input logic [N-1:0] r, input int n);
    int target;
    target = done_cnt + n;
    predict(r, n);
    req = r;
    wait_done(target, n * 40);
    req = '0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clock);
      if (ack != '0) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ack_timeout got=none expected=ack");
    end
  endtask

  initial begin
    bit ok;
    int target;
    logic [N-1:0] r;
    int sel;
    reset_n = 1'b0;
    req = '0;
    dado = '0;
    ult = N - 1;
    repeat (3) @(negedge clock);
    chk("rst_digits", 64'({saida4, saida3, saida2, saida1}), 64'(DISP_RESET));
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_fonte", 64'(fonte_ativa), 64'd0);
    chk("rst_estouro", 64'(estouro), 64'd0);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    set_dado(0, 32'd1234);
    run_batch(4'b0001, 1);

    set_dado(0, 32'd11); set_dado(1, 32'd2222); set_dado(2, 32'd303); set_dado(3, 32'd4044);
    run_batch(4'b1111, 5);

    set_dado(2, 32'd10000); set_dado(3, 32'd9999);
    run_batch(4'b1100, 2);

    set_dado(1, 32'd7);
    run_batch(4'b0010, 1);

    set_dado(0, 32'd0);
    run_batch(4'b0001, 1);

    // Source value changes right after capture; the display must keep the captured value
    set_dado(0, 32'd321);
    target = done_cnt + 1;
    predict(4'b0001, 1);
    req = 4'b0001;
    wait_ack(ok);
    @(negedge clock);
    set_dado(0, 32'd999);
    req = '0;
    wait_done(target, 40);
    repeat (3) @(negedge clock);

    for (int b = 0; b < 8; b++) begin
      r = N'($urandom_range(1, 15));
      for (int s = 0; s < N; s++) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: set_dado(s, 32'd0);
          1: set_dado(s, 32'd9999);
          2: set_dado(s, 32'd10000);
          3: set_dado(s, $urandom);
          default: set_dado(s, 32'($urandom_range(0, 9999)));
        endcase
      end
      run_batch(r, $urandom_range(1, 4));
    end

    // Reset in the 7th CONVERTE cycle aborts the conversion
    set_dado(3, 32'd5678);
    predict(4'b1000, 1);
    req = 4'b1000;
    wait_ack(ok);
    req = '0;
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_digits", 64'({saida4, saida3, saida2, saida1}), 64'(DISP_RESET));
    chk("abort_ocupado", 64'(ocupado), 64'd0);
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_estouro", 64'(estouro), 64'd0);
    exp_q.delete();
    ult = N - 1;
    set_dado(0, 32'd42); set_dado(1, 32'd8765); set_dado(3, 32'd123456);
    target = done_cnt + 3;
    predict(4'b1011, 3);
    req = 4'b1011;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_done(target, 120);
    req = '0;
    repeat (3) @(negedge clock);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
